// File: rtl/uartm_rx_frm.sv
// uartm_rx_frm - UART-master receive path and command framer.
//
// Oversampling byte receiver (start validation, optional parity, stop check)
// feeding a little-endian word assembler and a command framer that produces
// CMD / ADDR / optional WDATA host commands for the AHB-lite master sequencer.
//
// Optional feature macro: UARTM_RX_BREAK_DET_EN (adds brk_det output and
// break handling; when undefined a break is an ordinary framing error).
//
// Ports:
//   hclk, hreset        clock, asynchronous active-high reset
//   RX                  serial input (idle high), synchronised internally
//   baud_div            oversample tick every baud_div+1 hclk cycles
//   ctl_wsize           word size 00=8b 01=16b 10=32b 11=8b
//   ctl_par_en          parity bit present
//   ctl_par_even        1=even, 0=odd parity
//   cmd_valid/ready     command handshake
//   cmd_write           1=write, 0=read
//   cmd_addr            command address (zero-extended)
//   cmd_wdata           write data (zero-extended, 0 for reads)
//   rx_busy             byte receiver not idle
//   err_par/frm/ovr     sticky parity / framing / overrun errors
//   err_clr             clears all sticky errors (a same-cycle set wins)
//   brk_det             sticky break detect (UARTM_RX_BREAK_DET_EN only)
module uartm_rx_frm #(
  parameter int unsigned OSR         = 16,
  parameter int unsigned BAUD_W      = 16,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        ctl_wsize,
  input  logic              ctl_par_en,
  input  logic              ctl_par_even,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [AW-1:0]     cmd_addr,
  output logic [DW-1:0]     cmd_wdata,
  output logic              rx_busy,
  output logic              err_par,
  output logic              err_frm,
  output logic              err_ovr,
  input  logic              err_clr
`ifdef UARTM_RX_BREAK_DET_EN
  ,
  output logic              brk_det
`endif
);

  localparam int unsigned TW = $clog2(OSR);

  typedef enum logic [2:0] {
    B_IDLE, B_START, B_DATA, B_PAR, B_STOP
`ifdef UARTM_RX_BREAK_DET_EN
    , B_BRK
`endif
  } b_state_t;

  typedef enum logic [2:0] {C_IDLE, C_CMD, C_ADDR, C_WDATA, C_OUT} c_state_t;

  // Tracks a command arriving while the previous one is still being held in
  // C_OUT, so the overrun is flagged on that command's last byte.
  typedef enum logic [1:0] {O_IDLE, O_CMD, O_ADDR, O_WDATA} o_state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   fall;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RX};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev & ~rx_s;

  // ---------------------------------------------------------------- ticks
  logic [BAUD_W-1:0] baud_cnt;
  logic              tick;

  assign tick = (baud_cnt == baud_div);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)    baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- byte FSM
  b_state_t   b_state, b_next;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_tgt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          sample;
  logic          start_ev;
  logic          byte_done;
  logic          set_par;
  logic          set_frm;
  logic          brk_ev;
  logic          par_exp;

  logic [1:0]    cfg_wsize;
  logic          cfg_par_en;
  logic          cfg_par_even;

`ifdef UARTM_RX_BREAK_DET_EN
  logic          all_low;
`endif

  assign tick_tgt = (b_state == B_START) ? TW'(OSR/2 - 1) : TW'(OSR - 1);
  assign sample   = tick && (tick_cnt == tick_tgt);
  assign start_ev = (b_state == B_IDLE) && fall;
  assign par_exp  = cfg_par_even ? ^shreg : ~^shreg;
  assign rx_busy  = (b_state != B_IDLE);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) b_state <= B_IDLE;
    else        b_state <= b_next;
  end

  always_comb begin
    b_next    = b_state;
    byte_done = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    brk_ev    = 1'b0;
    case (b_state)
      B_IDLE:  if (fall) b_next = B_START;
      B_START: if (sample) b_next = rx_s ? B_IDLE : B_DATA;
      B_DATA:  if (sample && bit_cnt == 3'd7) b_next = cfg_par_en ? B_PAR : B_STOP;
      B_PAR: begin
        if (sample) begin
          b_next  = B_STOP;
          set_par = (rx_s != par_exp);
        end
      end
      B_STOP: begin
        if (sample) begin
          b_next = B_IDLE;
          if (rx_s) byte_done = !par_bad;
`ifdef UARTM_RX_BREAK_DET_EN
          else if (all_low) begin
            // Whole frame low: treat as break and wait for line release.
            brk_ev = 1'b1;
            b_next = B_BRK;
          end
`endif
          else set_frm = 1'b1;
        end
      end
`ifdef UARTM_RX_BREAK_DET_EN
      B_BRK:   if (rx_s) b_next = B_IDLE;
`endif
      default: b_next = B_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
`ifdef UARTM_RX_BREAK_DET_EN
      all_low  <= 1'b0;
`endif
    end else begin
      if (b_state == B_IDLE) tick_cnt <= '0;
      else if (sample)       tick_cnt <= '0;
      else if (tick)         tick_cnt <= tick_cnt + 1'b1;

      if (b_state == B_START) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
`ifdef UARTM_RX_BREAK_DET_EN
        all_low <= 1'b1;
`endif
      end
      if (b_state == B_DATA && sample) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rx_s, shreg[7:1]};
`ifdef UARTM_RX_BREAK_DET_EN
        all_low <= all_low & ~rx_s;
`endif
      end
      if (b_state == B_PAR && sample) begin
        if (set_par) par_bad <= 1'b1;
`ifdef UARTM_RX_BREAK_DET_EN
        all_low <= all_low & ~rx_s;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- framer
  c_state_t c_state, c_next;
  o_state_t o_state, o_next;
  logic [1:0]  beat;
  logic [31:0] word;
  logic [31:0] word_cur;
  logic        last_beat;
  logic        byte_acc;
  logic        word_done;
  logic        frame_err;
  logic        accept;
  logic        latch_cfg;
  logic        ld_cmd, ld_addr, ld_wdata, ld_ovr_cmd;
  logic        set_ovr;
  logic        ovr_write;

  assign frame_err = set_par | set_frm | brk_ev;
  assign accept    = (c_state == C_OUT) && cmd_ready;
  assign cmd_valid = (c_state == C_OUT);
  assign latch_cfg = start_ev &&
                     ((c_state == C_IDLE) || (c_state == C_OUT && o_state == O_IDLE));
  // Bytes only count while a command (real or overrunning) is being framed.
  assign byte_acc  = byte_done && (c_state != C_IDLE) &&
                     !(c_state == C_OUT && o_state == O_IDLE);
  assign word_done = byte_acc && last_beat;

  always_comb begin
    case (cfg_wsize)
      2'b01:   last_beat = (beat == 2'd1);
      2'b10:   last_beat = (beat == 2'd3);
      default: last_beat = 1'b1;
    endcase
  end

  always_comb begin
    word_cur = word;
    case (beat)
      2'd0:    word_cur[7:0]   = shreg;
      2'd1:    word_cur[15:8]  = shreg;
      2'd2:    word_cur[23:16] = shreg;
      default: word_cur[31:24] = shreg;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cfg_wsize    <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_even <= 1'b0;
      beat         <= '0;
      word         <= '0;
    end else begin
      if (latch_cfg) begin
        cfg_wsize    <= ctl_wsize;
        cfg_par_en   <= ctl_par_en;
        cfg_par_even <= ctl_par_even;
      end
      if (frame_err || accept) begin
        beat <= '0;
        word <= '0;
      end else if (byte_acc) begin
        if (last_beat) begin
          beat <= '0;
          word <= '0;
        end else begin
          beat <= beat + 1'b1;
          word <= word_cur;
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      c_state <= C_IDLE;
      o_state <= O_IDLE;
    end else begin
      c_state <= c_next;
      o_state <= o_next;
    end
  end

  always_comb begin
    c_next     = c_state;
    o_next     = O_IDLE;
    ld_cmd     = 1'b0;
    ld_addr    = 1'b0;
    ld_wdata   = 1'b0;
    ld_ovr_cmd = 1'b0;
    set_ovr    = 1'b0;
    case (c_state)
      C_IDLE: if (start_ev) c_next = C_CMD;
      C_CMD: begin
        if (frame_err) c_next = C_IDLE;
        else if (word_done) begin
          ld_cmd = 1'b1;
          c_next = C_ADDR;
        end
      end
      C_ADDR: begin
        if (frame_err) c_next = C_IDLE;
        else if (word_done) begin
          ld_addr = 1'b1;
          c_next  = cmd_write ? C_WDATA : C_OUT;
        end
      end
      C_WDATA: begin
        if (frame_err) c_next = C_IDLE;
        else if (word_done) begin
          ld_wdata = 1'b1;
          c_next   = C_OUT;
        end
      end
      C_OUT: begin
        o_next = o_state;
        case (o_state)
          O_IDLE: if (start_ev) o_next = O_CMD;
          O_CMD: begin
            if (frame_err) o_next = O_IDLE;
            else if (word_done) begin
              ld_ovr_cmd = 1'b1;
              o_next     = O_ADDR;
            end
          end
          O_ADDR: begin
            if (frame_err) o_next = O_IDLE;
            else if (word_done) begin
              o_next  = ovr_write ? O_WDATA : O_IDLE;
              set_ovr = !ovr_write;
            end
          end
          default: begin
            if (frame_err) o_next = O_IDLE;
            else if (word_done) begin
              o_next  = O_IDLE;
              set_ovr = 1'b1;
            end
          end
        endcase
        if (accept) begin
          c_next = C_IDLE;
          o_next = O_IDLE;
        end
      end
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      ovr_write <= 1'b0;
    end else begin
      if (ld_cmd) begin
        cmd_write <= word_cur[0];
        cmd_wdata <= '0;
      end
      if (ld_addr)    cmd_addr   <= AW'(word_cur);
      if (ld_wdata)   cmd_wdata  <= DW'(word_cur);
      if (ld_ovr_cmd) ovr_write  <= word_cur[0];
    end
  end

  // ---------------------------------------------------------------- errors
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      err_par <= 1'b0;
      err_frm <= 1'b0;
      err_ovr <= 1'b0;
    end else begin
      if (set_par)      err_par <= 1'b1;
      else if (err_clr) err_par <= 1'b0;
      if (set_frm)      err_frm <= 1'b1;
      else if (err_clr) err_frm <= 1'b0;
      if (set_ovr)      err_ovr <= 1'b1;
      else if (err_clr) err_ovr <= 1'b0;
    end
  end

`ifdef UARTM_RX_BREAK_DET_EN
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)       brk_det <= 1'b0;
    else if (brk_ev)  brk_det <= 1'b1;
    else if (err_clr) brk_det <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uartm_rx_frm.sv
module tb_uartm_rx_frm;
  localparam int unsigned OSR = 16;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        RX;
  logic [15:0] baud_div;
  logic [1:0]  ctl_wsize;
  logic        ctl_par_en;
  logic        ctl_par_even;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rx_busy;
  logic        err_par;
  logic        err_frm;
  logic        err_ovr;
  logic        err_clr;
`ifdef UARTM_RX_BREAK_DET_EN
  logic        brk_det;
`endif

  always #5 hclk = ~hclk;

  uartm_rx_frm #(.OSR(OSR), .BAUD_W(16), .AW(32), .DW(32), .SYNC_STAGES(2)) dut (
    .hclk(hclk), .hreset(hreset), .RX(RX), .baud_div(baud_div),
    .ctl_wsize(ctl_wsize), .ctl_par_en(ctl_par_en), .ctl_par_even(ctl_par_even),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rx_busy(rx_busy),
    .err_par(err_par), .err_frm(err_frm), .err_ovr(err_ovr), .err_clr(err_clr)
`ifdef UARTM_RX_BREAK_DET_EN
    , .brk_det(brk_det)
`endif
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        acc_prev = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  // Monitor: compares every accepted command against the scoreboard queue.
  always @(negedge hclk) begin
    cmd_t e;
    if (acc_prev) chk("valid_drop", {31'd0, cmd_valid}, 32'd0);
    acc_prev = 1'b0;
    if (!hreset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("cmd_write", {31'd0, cmd_write}, {31'd0, e.w});
        chk("cmd_addr", cmd_addr, e.a);
        chk("cmd_wdata", cmd_wdata, e.d);
      end
      acc_prev = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge hclk);
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    cyc((int'(baud_div) + 1) * OSR);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (ctl_par_en) send_bit((ctl_par_even ? ^d : ~^d) ^ flip);
    send_bit(1'b1);
  endtask

  task automatic send_seq(input logic [7:0] b [$]);
    foreach (b[i]) send_byte(b[i], 1'b0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_err_par"}, {31'd0, err_par}, 32'd0);
    chk({tag, "_err_frm"}, {31'd0, err_frm}, 32'd0);
    chk({tag, "_err_ovr"}, {31'd0, err_ovr}, 32'd0);
  endtask

  initial begin
    hreset = 1'b1; RX = 1'b1; baud_div = '0; ctl_wsize = 2'b00;
    ctl_par_en = 1'b0; ctl_par_even = 1'b0; cmd_ready = 1'b0; err_clr = 1'b0;
    cyc(5);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    chk_errs("rst");
    hreset = 1'b0;
    cyc(5);

    // 8-bit write: CMD 0x01, ADDR 0x40, WDATA 0xA5; held then accepted.
    exp_q.push_back('{w: 1'b1, a: 32'h40, d: 32'hA5});
    send_seq('{8'h01, 8'h40, 8'hA5});
    chk("t1_valid_held", {31'd0, cmd_valid}, 32'd1);
    cmd_ready = 1'b1;
    cyc(5);
    chk_errs("t1");

    // 32-bit read with even parity.
    ctl_wsize = 2'b10; ctl_par_en = 1'b1; ctl_par_even = 1'b1;
    exp_q.push_back('{w: 1'b0, a: 32'h12345678, d: 32'h0});
    send_seq('{8'h00, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    cyc(5);
    chk_errs("t2");

    // Odd parity, bad parity on the ADDR byte aborts the command.
    ctl_wsize = 2'b00; ctl_par_even = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h66, 1'b1);
    cyc(5);
    chk("t3_err_par_set", {31'd0, err_par}, 32'd1);
    chk("t3_err_frm", {31'd0, err_frm}, 32'd0);
    exp_q.push_back('{w: 1'b0, a: 32'h77, d: 32'h0});
    send_seq('{8'h00, 8'h77});
    cyc(5);
    chk("t3_err_par_sticky", {31'd0, err_par}, 32'd1);
    pulse_clr();
    chk("t3_err_par_clr", {31'd0, err_par}, 32'd0);

    // Overrun: 16-bit write held, a second command arrives and is dropped.
    ctl_wsize = 2'b01; ctl_par_en = 1'b0; cmd_ready = 1'b0;
    exp_q.push_back('{w: 1'b1, a: 32'hBEEF, d: 32'h1234});
    send_seq('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'h34, 8'h12});
    cyc(3);
    chk("t5_valid", {31'd0, cmd_valid}, 32'd1);
    send_seq('{8'h00, 8'h00, 8'h55, 8'h55});
    cyc(3);
    chk("t5_err_ovr", {31'd0, err_ovr}, 32'd1);
    chk("t5_addr_hold", cmd_addr, 32'hBEEF);
    chk("t5_wdata_hold", cmd_wdata, 32'h1234);
    chk("t5_write_hold", {31'd0, cmd_write}, 32'd1);
    cmd_ready = 1'b1;
    cyc(3);
    chk("t5_valid_after", {31'd0, cmd_valid}, 32'd0);
    pulse_clr();
    chk("t5_err_ovr_clr", {31'd0, err_ovr}, 32'd0);

    // 2-cycle glitch at baud_div=3: false start, no byte, no error.
    ctl_wsize = 2'b00; baud_div = 16'd3;
    RX = 1'b0;
    cyc(2);
    RX = 1'b1;
    cyc(6);
    chk("t4_busy_glitch", {31'd0, rx_busy}, 32'd1);
    cyc(45);
    chk("t4_busy_idle", {31'd0, rx_busy}, 32'd0);
    chk_errs("t4");

    // Reset mid-byte in the WDATA phase, then a fresh command.
    baud_div = '0;
    cyc(OSR * 2);
    send_seq('{8'h01, 8'h22});
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t6_busy_pre", {31'd0, rx_busy}, 32'd1);
    RX = 1'b1;
    hreset = 1'b1;
    cyc(3);
    chk("t6_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("t6_cmd_write", {31'd0, cmd_write}, 32'd0);
    chk("t6_cmd_addr", cmd_addr, 32'd0);
    chk("t6_cmd_wdata", cmd_wdata, 32'd0);
    chk("t6_rx_busy", {31'd0, rx_busy}, 32'd0);
    chk_errs("t6");
    hreset = 1'b0;
    cyc(5);
    exp_q.push_back('{w: 1'b1, a: 32'h33, d: 32'h5C});
    send_seq('{8'h01, 8'h33, 8'h5C});
    cyc(5);

`ifdef UARTM_RX_BREAK_DET_EN
    RX = 1'b0;
    cyc(12 * OSR);
    chk("brk_det", {31'd0, brk_det}, 32'd1);
    chk("brk_err_frm", {31'd0, err_frm}, 32'd0);
    RX = 1'b1;
    cyc(2 * OSR);
    chk("brk_busy", {31'd0, rx_busy}, 32'd0);
    exp_q.push_back('{w: 1'b0, a: 32'h44, d: 32'h0});
    send_seq('{8'h00, 8'h44});
    cyc(5);
    pulse_clr();
    chk("brk_clr", {31'd0, brk_det}, 32'd0);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uartm_rx_frm.md
Name: uartm_rx_frm

Overview:
- Parametrised next-generation UART-master receive path: on-chip bit timing with oversampling, start-bit validation, optional parity and stop-bit checking.
- Assembles bytes into 8/16/32-bit words and frames them into host bus commands (CMD, ADDR, optional WDATA).
- Presents each completed command to the AHB-lite master logic over a valid/ready handshake, with sticky error reporting.
- Sits between the RX pad synchroniser and the uartm AHB master sequencer.

Parameters:
- OSR, 16: oversample ticks per bit; even number, >=4.
- BAUD_W, 16: width of baud divisor.
- AW, 32: command address width.
- DW, 32: command write-data width; must be 32.
- SYNC_STAGES, 2: RX synchroniser flops; >=2.

Ports:
- hclk  in  1  clock
- hreset  in  1  asynchronous reset, active-high
- RX  in  1  serial input, idle high
- baud_div  in  BAUD_W  one oversample tick every baud_div+1 hclk cycles
- ctl_wsize  in  2  word size: 00=8b, 01=16b, 10=32b, 11=8b
- ctl_par_en  in  1  parity bit present
- ctl_par_even  in  1  1=even parity, 0=odd parity
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts command
- cmd_write  out  1  1=write, 0=read
- cmd_addr  out  AW  command address, zero-extended
- cmd_wdata  out  DW  write data, zero-extended; 0 for reads
- rx_busy  out  1  byte receiver not idle
- err_par  out  1  sticky parity error
- err_frm  out  1  sticky framing error
- err_ovr  out  1  sticky overrun error
- err_clr  in  1  clears all sticky errors

Behaviour:
- Reset: all outputs 0; both FSMs in idle state; synchroniser flops preset to 1.
- Tick generator: counter runs continuously; one-cycle tick when counter == baud_div, then reloads 0. baud_div=0 gives a tick every cycle.
- Byte FSM, states B_IDLE, B_START, B_DATA, B_PAR, B_STOP:
  - B_IDLE: a synchronised falling edge (1->0) moves to B_START and resets the tick count.
  - B_START: after OSR/2 ticks, re-sample RX. If high, false start: return to B_IDLE with no error. If low, go to B_DATA.
  - B_DATA: sample every OSR ticks, 8 bits, LSB first.
  - B_PAR: entered only if ctl_par_en; samples parity after OSR ticks. Mismatch sets err_par.
  - B_STOP: sample after OSR ticks. A 0 sets err_frm. Issue a byte_done pulse in the sample cycle only if no error. Then B_IDLE.
  - rx_busy = (byte state != B_IDLE).
- Word assembly: beats per word = 1/2/4 by ctl_wsize. Little-endian: first byte goes to bits [7:0]. Word completes on its last byte_done.
- ctl_wsize, ctl_par_en and ctl_par_even are latched on the B_IDLE->B_START transition of the first byte of a command and held until the command completes or aborts.
- Command FSM, states C_IDLE, C_CMD, C_ADDR, C_WDATA, C_OUT:
  - C_IDLE: first falling edge -> C_CMD.
  - C_CMD: on word complete, store cmd_write = word[0] -> C_ADDR.
  - C_ADDR: on word complete, store address; if write -> C_WDATA, else -> C_OUT.
  - C_WDATA: on word complete, store data -> C_OUT.
  - C_OUT: cmd_valid=1 with cmd_write/cmd_addr/cmd_wdata stable until cmd_valid && cmd_ready; then C_IDLE. cmd_valid drops the cycle after acceptance.
  - Latency: cmd_valid rises one cycle after the final byte_done.
- Overrun: a falling edge seen while in C_OUT is received but discarded. Its last byte_done sets err_ovr; cmd_* stay unchanged.
- Abort: any err_par or err_frm during C_CMD/C_ADDR/C_WDATA discards the partial command -> C_IDLE.
- Sticky errors: err_clr clears all three. If a set and err_clr occur in the same cycle, set wins.
- Reset mid-byte or mid-command: everything returns to reset values; the next falling edge starts a fresh command.

Optional Feature:
- UARTM_RX_BREAK_DET_EN defined:
  - Adds output brk_det (1 bit, sticky, cleared by err_clr).
  - Set when RX samples low for the start bit, all 8 data bits, the parity bit (if present) and the stop bit.
  - On break: err_frm is not set, the command FSM aborts to C_IDLE, and the byte FSM waits for RX high before re-arming.
- Undefined: no brk_det port; a break is handled as an ordinary framing error.

Test Plan:
- baud_div=0, OSR=16, wsize=00, no parity; send bytes 0x01, 0x40, 0xA5 -> cmd_valid one cycle after the last stop sample; cmd_write=1, cmd_addr=0x40, cmd_wdata=0xA5.
- wsize=10, even parity; send read CMD 0x00000000, ADDR 0x12345678 -> cmd_write=0, cmd_addr=0x12345678, cmd_wdata=0, no errors.
- Odd parity selected, byte sent with a wrong parity bit during C_ADDR -> err_par=1, no cmd_valid, next command decodes normally; err_clr pulse -> err_par=0.
- 2-tick low glitch on RX (baud_div=3) -> no byte, rx_busy returns 0 within OSR/2 ticks, no error flags.
- Hold cmd_ready=0 and send a second full command -> err_ovr=1; first command's fields unchanged; set cmd_ready=1 -> accepted, C_IDLE.
- Assert hreset mid-byte during C_WDATA -> all outputs 0; the following full command decodes correctly. With UARTM_RX_BREAK_DET_EN, 12 bit-times low -> brk_det=1, err_frm=0.
